// File: rtl/dynamic_pattern_det_if.sv
// Configuration, stream and status signals of the runtime-programmable pattern detector.
// master drives configuration and data; slave is the detector.
interface dynamic_pattern_det_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               data_valid;
  logic               data_in;
  logic               cnt_clr;
  logic               pattern_det;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in, cnt_clr,
    input  pattern_det, match_count, armed
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in, cnt_clr,
    output pattern_det, match_count, armed
  );
endinterface

// File: rtl/dynamic_pattern_det.sv
// Serial pattern detector with a runtime-loaded pattern, length and overlap mode.
// Emits a registered one-cycle pulse per match and keeps a saturating match count.
module dynamic_pattern_det #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  dynamic_pattern_det_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StMatch} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q, hist_q;
  logic [LEN_W-1:0]   len_q, fill_q;
  logic               ovl_q, det_q, armed_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] hist_shift, mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               accept, hit, cfg_ok;

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], bus.data_in};
    fill_inc   = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    cfg_ok = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= MAX_LEN);
    // A configuration write in the same cycle discards the data bit.
    accept = bus.data_valid && (state_q != StIdle) && !bus.cfg_we;
    hit    = accept && (((hist_shift ^ pat_q) & mask) == '0) && (fill_inc == len_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      det_q <= 1'b0;
      if (bus.cfg_we) begin
        pat_q   <= bus.cfg_pattern;
        len_q   <= bus.cfg_len;
        ovl_q   <= bus.cfg_overlap;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= cfg_ok ? StFill : StIdle;
        armed_q <= cfg_ok;
      end else if (accept) begin
        hist_q <= hist_shift;
        if (hit) begin
          det_q <= 1'b1;
          if (ovl_q) begin
            fill_q  <= fill_inc;
            state_q <= StMatch;
          end else begin
            // Restart filling so no bit of this match is reused.
            fill_q  <= '0;
            state_q <= StFill;
          end
        end else begin
          fill_q  <= fill_inc;
          state_q <= (fill_inc == len_q) ? StMatch : StFill;
        end
      end

      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pattern_det = det_q;
  assign bus.match_count = cnt_q;
  assign bus.armed       = armed_q;

endmodule

// File: tb/tb_dynamic_pattern_det.sv
// Directed bench for dynamic_pattern_det: a CNT_W=8 instance plus a CNT_W=2 instance
// sharing the same stimulus so saturation can be observed.
module tb_dynamic_pattern_det;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dynamic_pattern_det_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) bus ();
  dynamic_pattern_det_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) bus2 ();

  assign bus2.cfg_we      = bus.cfg_we;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.data_valid  = bus.data_valid;
  assign bus2.data_in     = bus.data_in;
  assign bus2.cnt_clr     = bus.cnt_clr;

  dynamic_pattern_det #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  dynamic_pattern_det #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller sets data_valid/data_in beforehand to exercise config-vs-data priority.
  task automatic cfg(input logic [15:0] pat, input logic [4:0] len, input logic ovl);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cfg_we      = 1'b1;
    tick();
    bus.cfg_we      = 1'b0;
    bus.data_valid  = 1'b0;
  endtask

  task automatic sbit(input logic d, input logic exp, input string tag);
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    tick();
    bus.data_valid = 1'b0;
    chk(tag, 32'(bus.pattern_det), 32'(exp));
  endtask

  // bits[n-1] is sent first; exp[k] is the detect expected after sending bits[k].
  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      sbit(bits[i], exp[i], $sformatf("%s[%0d]", tag, n - 1 - i));
    end
  endtask

  task automatic clr();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    chk("clr_cnt", 32'(bus.match_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] gap_bits;
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.data_valid = 1'b0; bus.data_in = 1'b0; bus.cnt_clr = 1'b0;

    // Reset with random inputs
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we      = 1'($urandom);
      bus.cfg_pattern = 16'($urandom);
      bus.cfg_len     = 5'($urandom);
      bus.cfg_overlap = 1'($urandom);
      bus.data_valid  = 1'($urandom);
      bus.data_in     = 1'($urandom);
      bus.cnt_clr     = 1'($urandom);
      tick();
    end
    chk("rst_det", 32'(bus.pattern_det), 32'd0);
    chk("rst_cnt", 32'(bus.match_count), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.data_valid = 1'b0; bus.data_in = 1'b0; bus.cnt_clr = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_det", 32'(bus.pattern_det), 32'd0);
    chk("post_rst_cnt", 32'(bus.match_count), 32'd0);
    chk("post_rst_armed", 32'(bus.armed), 32'd0);
    stream(16'b10110, 16'b0, 5, "idle");
    chk("idle_cnt", 32'(bus.match_count), 32'd0);

    // Overlapping 5-bit pattern
    cfg(16'b10110, 5'd5, 1'b1);
    chk("ovl_armed", 32'(bus.armed), 32'd1);
    stream(16'b10110110, 16'b00001001, 8, "ovl5");
    chk("ovl5_cnt", 32'(bus.match_count), 32'd2);
    chk("ovl5_cnt_sat", 32'(bus2.match_count), 32'd2);
    clr();

    // Non-overlapping 5-bit pattern
    cfg(16'b10110, 5'd5, 1'b0);
    stream(16'b10110110, 16'b00001000, 8, "novl5");
    chk("novl5_cnt", 32'(bus.match_count), 32'd1);
    clr();

    // Two-bit pattern of ones
    cfg(16'b11, 5'd2, 1'b1);
    stream(16'b1111, 16'b0111, 4, "ovl11");
    chk("ovl11_cnt", 32'(bus.match_count), 32'd3);
    clr();
    cfg(16'b11, 5'd2, 1'b0);
    stream(16'b1111, 16'b0101, 4, "novl11");
    chk("novl11_cnt", 32'(bus.match_count), 32'd2);
    clr();

    // Three idle cycles between each valid bit
    cfg(16'b10110, 5'd5, 1'b1);
    gap_bits = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      sbit(gap_bits[i], (i == 0), $sformatf("gap_bit[%0d]", 4 - i));
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("gap_idle", 32'(bus.pattern_det), 32'd0);
        end
      end
    end
    chk("gap_cnt", 32'(bus.match_count), 32'd1);
    clr();

    // Reconfigure mid-match; concurrent data bit is dropped and history cleared
    cfg(16'b10110, 5'd5, 1'b1);
    stream(16'b101, 16'b000, 3, "pre_recfg");
    bus.data_valid = 1'b1;
    bus.data_in    = 1'b1;
    cfg(16'b10110, 5'd5, 1'b1);
    chk("cfg_vs_data_det", 32'(bus.pattern_det), 32'd0);
    stream(16'b10, 16'b00, 2, "post_recfg");
    cfg(16'b10110, 5'd0, 1'b1);
    chk("len0_armed", 32'(bus.armed), 32'd0);
    stream(16'b10110, 16'b0, 5, "len0");
    chk("recfg_cnt", 32'(bus.match_count), 32'd0);

    // Oversized length disarms; full-length pattern works
    cfg(16'b10110, 5'd17, 1'b1);
    chk("len17_armed", 32'(bus.armed), 32'd0);
    cfg(16'hA5C3, 5'd16, 1'b0);
    chk("len16_armed", 32'(bus.armed), 32'd1);
    stream(16'hA5C3, 16'h0001, 16, "len16");
    chk("len16_cnt", 32'(bus.match_count), 32'd1);
    clr();

    // Saturation on the 2-bit counter, then clear-vs-match priority
    cfg(16'b1, 5'd1, 1'b1);
    stream(16'b11111, 16'b11111, 5, "sat");
    chk("sat_cnt8", 32'(bus.match_count), 32'd5);
    chk("sat_cnt2", 32'(bus2.match_count), 32'd3);
    bus.cnt_clr    = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 1'b1;
    tick();
    bus.cnt_clr    = 1'b0;
    bus.data_valid = 1'b0;
    chk("clr_match_det", 32'(bus.pattern_det), 32'd1);
    chk("clr_match_cnt8", 32'(bus.match_count), 32'd0);
    chk("clr_match_cnt2", 32'(bus2.match_count), 32'd0);

    // Length-1 non-overlap
    cfg(16'b0, 5'd1, 1'b0);
    stream(16'b010, 16'b101, 3, "len1");
    chk("len1_cnt", 32'(bus.match_count), 32'd2);

    // Reset mid-stream clears an in-flight pulse and disarms
    cfg(16'b10110, 5'd5, 1'b1);
    stream(16'b10110, 16'b00001, 5, "pre_rst");
    rst = 1'b0;
    #1;
    chk("mid_rst_det", 32'(bus.pattern_det), 32'd0);
    chk("mid_rst_armed", 32'(bus.armed), 32'd0);
    chk("mid_rst_cnt", 32'(bus.match_count), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    stream(16'b10110, 16'b0, 5, "post_mid_rst");
    chk("post_mid_rst_armed", 32'(bus.armed), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
